// File: rtl/down_counter_timer_pkg.sv
// Shared types and constants for the loadable down-counter/timer.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

  // Prescale counter width: $clog2(PRESCALE), never narrower than one bit.
  function automatic int unsigned prescale_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/down_counter_timer_prescaler.sv
// Tick generator: one-cycle tick_o on every PRESCALE-th enabled cycle.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Tick is asserted during the cycle whose closing edge performs the decrement.
  assign tick_o = en_i && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clear_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with prescaled ticks and a one-cycle done pulse.
// Define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN for periodic reload from the last loaded value.
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH    = TIMER_WIDTH,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [WIDTH-1:0] counter_o,
  output logic             busy_o,
  output logic             done_o
);

  timer_state_e     state_q;
  timer_state_e     state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             done_q;
  logic             done_d;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
`endif

  logic             tick_c;
  logic             pre_clear_c;
  logic [WIDTH-1:0] eff_count_c;

  // Prescaler restarts from zero whenever counting (re)begins or is interrupted.
  assign pre_clear_c = (state_q != RUN) || stop_i || load_i;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (pre_clear_c),
    .en_i    (state_q == RUN),
    .tick_o  (tick_c)
  );

  assign eff_count_c = load_i ? load_value_i : count_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      IDLE: begin
        if (!stop_i) begin
          if (load_i) begin
            count_d = load_value_i;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            reload_d = load_value_i;
`endif
          end
          // A zero-valued start completes immediately without entering RUN.
          if (start_i) begin
            if (eff_count_c != '0) begin
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (load_i) begin
          count_d = load_value_i;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          reload_d = load_value_i;
`endif
          if (load_value_i == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (tick_c) begin
          // Saturate at zero; the count never wraps to all-ones.
          if (count_q <= WIDTH'(1)) begin
            done_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            if (reload_q != '0) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
`else
            count_d = '0;
            state_d = IDLE;
`endif
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      done_q   <= done_d;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign counter_o = count_q;
  assign busy_o    = (state_q == RUN);
  assign done_o    = done_q;

endmodule
